// File: rtl/vga_number_overlay_if.sv
// Pixel-stage bundle for vga_number_overlay: timing-generator side drives i_*, overlay drives o_*.
// Carries no flow control; the pixel stream is free-running at the pixel clock.
interface vga_number_overlay_if;
  logic [13:0] i_value;
  logic        i_load;
  logic [9:0]  i_x;
  logic [8:0]  i_y;
  logic        i_active;
  logic        i_hs;
  logic        i_vs;
  logic [11:0] o_rgb;
  logic        o_pixel_on;
  logic        o_hs;
  logic        o_vs;
  logic        o_busy;

  modport master (
    output i_value, i_load, i_x, i_y, i_active, i_hs, i_vs,
    input  o_rgb, o_pixel_on, o_hs, o_vs, o_busy
  );

  modport slave (
    input  i_value, i_load, i_x, i_y, i_active, i_hs, i_vs,
    output o_rgb, o_pixel_on, o_hs, o_vs, o_busy
  );
endinterface

// File: rtl/vga_number_overlay.sv
// Four-digit seven-segment overlay with per-frame double-dabble BCD conversion; 1-cycle pixel latency, no backpressure.
// LEADING_ZERO_BLANK_EN: when defined, leading zero digits render as background (digit 3 always shown).
module vga_number_overlay #(
  parameter int          X0         = 100,
  parameter int          Y0         = 50,
  parameter int          SCALE_LOG2 = 2,
  parameter logic [11:0] FG         = 12'hFFF,
  parameter logic [11:0] BG         = 12'h000
) (
  input logic              i_clk,
  input logic              i_rst,
  vga_number_overlay_if.slave px
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_adj;

  logic [11:0] rgb_q, rgb_d;
  logic        pixel_on_q, pixel_on_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    // bit order {a,b,c,d,e,f,g}
    case (n)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: begin
        if (px.i_load) begin
          shift_d = (px.i_value > 14'd9999) ? 14'd9999 : px.i_value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = COMMIT;
      end
      COMMIT: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixel path: locate the cell, pick its nibble, test the seven segment rectangles.
  logic [10:0] lx, ly, u, v;
  logic [1:0]  dig;
  logic [2:0]  cu;
  logic [3:0]  rv, nib;
  logic [6:0]  segs;
  logic        in_cell, mid_u, seg_hit, blank, lit;

  always_comb begin
    lx      = {1'b0, px.i_x} - 11'(X0);
    ly      = {2'b0, px.i_y} - 11'(Y0);
    u       = lx >> SCALE_LOG2;
    v       = ly >> SCALE_LOG2;
    dig     = u[4:3];
    cu      = u[2:0];
    rv      = v[3:0];
    in_cell = !lx[10] && !ly[10] && (u[10:3] < 8'd4) && (cu < 3'd6) && (v < 11'd11);
    case (dig)
      2'd0:    nib = disp_q[15:12];
      2'd1:    nib = disp_q[11:8];
      2'd2:    nib = disp_q[7:4];
      default: nib = disp_q[3:0];
    endcase
    segs  = seg7(nib);
    mid_u = (cu >= 3'd1) && (cu <= 3'd4);
    seg_hit = (segs[6] && rv == 4'd0  && mid_u) ||
              (segs[5] && cu == 3'd5  && rv >= 4'd1 && rv <= 4'd4) ||
              (segs[4] && cu == 3'd5  && rv >= 4'd6 && rv <= 4'd9) ||
              (segs[3] && rv == 4'd10 && mid_u) ||
              (segs[2] && cu == 3'd0  && rv >= 4'd6 && rv <= 4'd9) ||
              (segs[1] && cu == 3'd0  && rv >= 4'd1 && rv <= 4'd4) ||
              (segs[0] && rv == 4'd5  && mid_u);
`ifdef LEADING_ZERO_BLANK_EN
    case (dig)
      2'd0:    blank = (disp_q[15:12] == 4'd0);
      2'd1:    blank = (disp_q[15:8]  == 8'd0);
      2'd2:    blank = (disp_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    lit        = in_cell && seg_hit && !blank;
    rgb_d      = !px.i_active ? 12'h000 : (lit ? FG : BG);
    pixel_on_d = px.i_active && lit;
    hs_d       = px.i_hs;
    vs_d       = px.i_vs;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      rgb_q      <= '0;
      pixel_on_q <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      rgb_q      <= rgb_d;
      pixel_on_q <= pixel_on_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
    end
  end

  assign px.o_rgb      = rgb_q;
  assign px.o_pixel_on = pixel_on_q;
  assign px.o_hs       = hs_q;
  assign px.o_vs       = vs_q;
  assign px.o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_vga_number_overlay.sv
// Scoreboard bench for vga_number_overlay: driver queues hand-computed expectations, monitor checks each cycle.
module tb_vga_number_overlay;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk;
  logic rst;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  vga_number_overlay_if vif ();

  vga_number_overlay dut (
    .i_clk (clk),
    .i_rst (rst),
    .px    (vif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    string       nm;
    int          cyc;
    logic [11:0] rgb;
    logic        pon;
    logic        hs;
    logic        vs;
    logic        cb;
    logic        eb;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Inputs change 1 time unit after an edge and are sampled by the next edge.
  task automatic cyc(input string nm, input logic r, input logic [9:0] x, input logic [8:0] y,
                     input logic act, input logic hs, input logic vs, input logic ld,
                     input logic [13:0] val, input logic lit, input logic cb, input logic eb);
    exp_t t;
    @(posedge clk);
    #1;
    rst          = r;
    vif.i_x      = x;
    vif.i_y      = y;
    vif.i_active = act;
    vif.i_hs     = hs;
    vif.i_vs     = vs;
    vif.i_load   = ld;
    vif.i_value  = val;
    t.nm  = nm;
    t.cyc = cyc_cnt + 1;
    t.cb  = cb;
    t.eb  = eb;
    if (r) begin
      t.rgb = 12'h000; t.pon = 1'b0; t.hs = 1'b1; t.vs = 1'b1;
    end else begin
      t.rgb = (act && lit) ? 12'hFFF : 12'h000;
      t.pon = act && lit;
      t.hs  = hs;
      t.vs  = vs;
    end
    q.push_back(t);
  endtask

  task automatic pix(input string nm, input logic [9:0] x, input logic [8:0] y, input logic lit);
    cyc(nm, 1'b0, x, y, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0, lit, 1'b0, 1'b0);
  endtask

  // Load at edge t; o_busy expected high after edges t..t+14, low after t+15.
  // The watched pixel must keep its old rendering through edge t+15.
  task automatic do_load(input string nm, input logic [13:0] val, input logic [9:0] x,
                         input logic [8:0] y, input logic old_lit, input int reload_at, input int rst_at);
    cyc(nm, 1'b0, x, y, 1'b1, 1'b1, 1'b1, 1'b1, val, old_lit, 1'b1, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      if (i == rst_at) begin
        cyc({nm, "_rst"}, 1'b1, x, y, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0);
        return;
      end
      cyc(nm, 1'b0, x, y, 1'b1, 1'b1, 1'b1, (i == reload_at), 14'd12000, old_lit, 1'b1, (i < 15));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        checks++;
        if (vif.o_rgb !== e.rgb || vif.o_pixel_on !== e.pon || vif.o_hs !== e.hs || vif.o_vs !== e.vs) begin
          errors++;
          $display("FAIL %s pix @%0d: got rgb=%h on=%b hs=%b vs=%b, want rgb=%h on=%b hs=%b vs=%b",
                   e.nm, e.cyc, vif.o_rgb, vif.o_pixel_on, vif.o_hs, vif.o_vs, e.rgb, e.pon, e.hs, e.vs);
        end
        if (e.cb) begin
          checks++;
          if (vif.o_busy !== e.eb) begin
            errors++;
            $display("FAIL %s busy @%0d: got %b, want %b", e.nm, e.cyc, vif.o_busy, e.eb);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    vif.i_x = '0; vif.i_y = '0; vif.i_active = 1'b0; vif.i_hs = 1'b0; vif.i_vs = 1'b0;
    vif.i_load = 1'b0; vif.i_value = '0;

    // Reset forces sync outputs high even though the inputs are low.
    for (int i = 0; i < 3; i++)
      cyc("reset", 1'b1, 10'd108, 9'd50, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0);

    do_load("ld0", 14'd0, 10'd204, 9'd50, 1'b1, -1, -1);
    pix("z_d3_a", 10'd204, 9'd50, 1'b1);
    pix("z_d0_a", 10'd108, 9'd50, !LZ);
    pix("z_d0_g", 10'd108, 9'd70, 1'b0);

    do_load("ld1234", 14'd1234, 10'd204, 9'd50, 1'b1, -1, -1);
    pix("n4_a_off",  10'd204, 9'd50, 1'b0);
    pix("n1_b",      10'd120, 9'd58, 1'b1);
    pix("n1_a_off",  10'd108, 9'd50, 1'b0);
    pix("n2_a",      10'd140, 9'd50, 1'b1);
    pix("n3_g",      10'd172, 9'd70, 1'b1);
    pix("n4_f",      10'd196, 9'd58, 1'b1);
    pix("n4_e_off",  10'd196, 9'd82, 1'b0);
    pix("gap",       10'd124, 9'd58, 1'b0);
    pix("below",     10'd108, 9'd94, 1'b0);
    pix("left_x0",   10'd99,  9'd50, 1'b0);
    pix("above_y0",  10'd108, 9'd49, 1'b0);
    cyc("inactive", 1'b0, 10'd120, 9'd58, 1'b0, 1'b1, 1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);

    do_load("ld12000", 14'd12000, 10'd204, 9'd70, 1'b1, -1, -1);
    pix("c9_g",     10'd108, 9'd70, 1'b1);
    pix("c9_f",     10'd100, 9'd58, 1'b1);
    pix("c9_c",     10'd120, 9'd82, 1'b1);
    pix("c9_e_off", 10'd100, 9'd82, 1'b0);
    pix("c9_d3_d",  10'd204, 9'd90, 1'b1);

    do_load("ld7", 14'd7, 10'd108, 9'd50, 1'b1, -1, -1);
    pix("s_d0_a",   10'd108, 9'd50, !LZ);
    pix("s_d0_f",   10'd100, 9'd58, !LZ);
    pix("s_d1_a",   10'd140, 9'd50, !LZ);
    pix("s7_a",     10'd204, 9'd50, 1'b1);
    pix("s7_b",     10'd216, 9'd58, 1'b1);
    pix("s7_g_off", 10'd204, 9'd70, 1'b0);
    pix("s7_f_off", 10'd196, 9'd58, 1'b0);

    do_load("ld_reload", 14'd1234, 10'd108, 9'd70, 1'b0, 5, -1);
    pix("r1_g_off", 10'd108, 9'd70, 1'b0);
    pix("r1_b",     10'd120, 9'd58, 1'b1);

    do_load("ld_abort", 14'd7, 10'd204, 9'd70, 1'b1, -1, 4);
    cyc("post_rst", 1'b0, 10'd204, 9'd70, 1'b1, 1'b1, 1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0);
    pix("a0_d3_a", 10'd204, 9'd50, 1'b1);
    pix("a0_d0_a", 10'd108, 9'd50, !LZ);

    // Sync pass-through with toggling patterns over a lit pixel held inactive.
    cyc("sync0", 1'b0, 10'd120, 9'd58, 1'b0, 1'b1, 1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
    cyc("sync1", 1'b0, 10'd120, 9'd58, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
    cyc("sync2", 1'b0, 10'd120, 9'd58, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
    cyc("sync3", 1'b0, 10'd120, 9'd58, 1'b0, 1'b1, 1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
    cyc("sync4", 1'b0, 10'd120, 9'd58, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
    cyc("sync5", 1'b0, 10'd120, 9'd58, 1'b0, 1'b1, 1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_number_overlay.md
# vga_number_overlay

Pixel-pipeline stage directly downstream of the 640x480 VGA timing generator. It latches a binary value once per frame and converts it to BCD with a sequential double-dabble during vertical blanking. It then renders the value as up to four seven-segment digits at a fixed screen position. Timing-generator pixel coordinates and syncs go in; RGB and syncs come out, delayed by one cycle so they stay aligned.

## Interface
- X0, 100: left edge of digit 0 (most significant), pixels
- Y0, 50: top edge of digits, pixels
- SCALE_LOG2, 2: segment unit = 2^SCALE_LOG2 pixels
- FG, 12'hFFF: RGB444 colour of lit segments
- BG, 12'h000: RGB444 colour of active pixels elsewhere

- i_clk  in  1  pixel clock
- i_rst  in  1  reset, synchronous, active-high
- i_value  in  14  binary value to display
- i_load  in  1  latch request (tie to timing generator o_animate)
- i_x  in  10  active-area x
- i_y  in  9  active-area y
- i_active  in  1  active-pixel flag
- i_hs, i_vs  in  1 each  syncs from timing generator
- o_rgb  out  12  pixel colour, RGB444
- o_pixel_on  out  1  high when current output pixel is a lit segment
- o_hs, o_vs  out  1 each  syncs delayed by 1 cycle
- o_busy  out  1  conversion in progress

## Operation
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: if i_load, latch min(i_value, 9999) into shift reg, clear BCD scratch, go to SHIFT.
  - SHIFT: 14 iterations. Each one adds 3 to any BCD nibble ≥5, then shifts left by 1, bringing in the next value MSB. An iteration counter of 4 bits runs from 0 to 13; at 13 the FSM goes to COMMIT.
  - COMMIT: copy 4 BCD nibbles into the display register, go to IDLE.
- Display register is separate from the scratch, so the rendered digits never change mid-conversion.
- i_load while not IDLE is ignored. o_busy = (state != IDLE).
- Geometry in segment units, with u = local x >> SCALE_LOG2 and v = local y >> SCALE_LOG2:
  - Digit cell is 6 wide by 11 tall. Digit pitch is 8 units (2-unit gap). Digit d occupies x from X0 + d·8·2^SCALE_LOG2.
- Segments, (u,v) in-cell:
  - a: v=0, u 1..4
  - b: u=5, v 1..4
  - c: u=5, v 6..9
  - d: v=10, u 1..4
  - e: u=0, v 6..9
  - f: u=0, v 1..4
  - g: v=5, u 1..4
- Standard 7-seg glyphs for 0-9. BCD nibbles 10-15 cannot occur.
- A pixel outside all cells is background.
- Output colours:
  - !i_active: o_rgb = 0 and o_pixel_on = 0.
  - active lit segment: FG.
  - otherwise: BG.
- Width rules: local coordinates are computed as unsigned 11-bit differences. A pixel left of X0 or above Y0 (negative difference) is outside the cells.

## Timing
- Reset values:
  - state IDLE, o_busy 0
  - display register 0000
  - o_rgb 0, o_pixel_on 0, o_hs 1, o_vs 1
- Reset mid-conversion aborts. The display register is cleared to 0000.
- Load accepted at edge t:
  - SHIFT runs on edges t+1..t+14.
  - COMMIT is at edge t+15.
  - New digits render for pixels sampled from edge t+16 onward.
  - o_busy is high cycles t+1..t+15.
- Conversion (16 cycles) completes well inside vertical blanking when i_load = o_animate.
- Pixel path latency is exactly 1 cycle. o_rgb, o_pixel_on, o_hs and o_vs at edge n+1 reflect inputs sampled at edge n.

## Configuration
- LEADING_ZERO_BLANK_EN defined: leading zero digits render as background, and digit 3 is always shown. Value 0 therefore shows a single "0" in the digit-3 position.
- Undefined: all four digits always rendered, including leading zeros.

## Test plan
- Reset held 3 cycles: o_rgb=0, o_hs=o_vs=1, o_busy=0. A load of 0 and the frame rendered afterwards show "0000" (macro off).
- i_value=1234, i_load pulse, defaults (unit 4 px):
  - o_busy high exactly 15 cycles.
  - Pixel (120,58) active gives FG (digit 1, seg b).
  - Pixel (108,50) gives BG (seg a unlit for '1').
  - Pixel (140,50) gives FG (digit '2', seg a).
- i_value=12000: displays 9999 (clamp). Pixel (108,70) gives FG (seg g of '9').
- i_value=7:
  - macro off: digits 0-2 show '0'.
  - macro on: pixels of digits 0-2 are BG; digit 3 shows '7'.
- Second i_load 5 cycles into a conversion is ignored: o_busy drops after 15 cycles total. Reset asserted during SHIFT: next rendered frame shows 0000.
- Input i_hs toggles at known cycles: o_hs mirrors it 1 cycle later. With i_active=0, o_rgb=0 regardless of digits.
